// File: rtl/ita_job_sequencer.sv
// ITA job sequencer: FIFO of {desc, irq_en} issued one job at a time as LOAD -> START pulse -> wait done.
// Start is 2 cycles after pop; push_ready_o drops while full, on abort_i, and while draining an aborted job.
module ita_job_sequencer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DESC_W = 128,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_valid_i,
  output logic                     push_ready_o,
  input  logic [DESC_W-1:0]        push_desc_i,
  input  logic                     push_irq_en_i,
  input  logic                     abort_i,
  output logic [DESC_W-1:0]        cfg_desc_o,
  output logic                     start_o,
  input  logic                     done_i,
  output logic                     active_o,
  output logic [$clog2(DEPTH):0]   pending_o,
  output logic [CNT_W-1:0]         completed_o,
  output logic                     irq_o,
  output logic                     err_o
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  typedef struct packed {
    logic [DESC_W-1:0] desc;
    logic              irq_en;
  } entry_t;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_RUN, S_ABORT} state_e;

  state_e            state_q, state_d;
  entry_t            mem_q [DEPTH];
  entry_t            head;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic [DESC_W-1:0] cfg_desc_q, cfg_desc_d;
  logic              irq_en_q, irq_en_d;
  logic [CNT_W-1:0]  completed_q, completed_d;
  logic              irq_q, irq_d;
  logic              err_q, err_d;

  logic empty, full, push_fire, pop, done_ok, done_bad;

  assign empty     = (count_q == '0);
  assign full      = (count_q == FULL_CNT);
  assign head      = mem_q[rd_ptr_q];

  assign push_ready_o = !full && (state_q != S_ABORT) && !abort_i;
  assign push_fire    = push_valid_i && push_ready_o;

  // Abort wins over any pop in the same cycle.
  assign pop = !abort_i && !empty &&
               ((state_q == S_IDLE) || ((state_q == S_RUN) && done_i));

  assign done_ok  = done_i && ((state_q == S_RUN) || (state_q == S_ABORT));
  assign done_bad = done_i && !done_ok;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!abort_i && !empty) state_d = S_LOAD;
      end
      S_LOAD: begin
        state_d = abort_i ? S_IDLE : S_START;
      end
      S_START: begin
        state_d = abort_i ? S_ABORT : S_RUN;
      end
      S_RUN: begin
        if (done_i) begin
          state_d = (!abort_i && !empty) ? S_LOAD : S_IDLE;
        end else if (abort_i) begin
          state_d = S_ABORT;
        end
      end
      S_ABORT: begin
        if (done_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    start_o  = (state_q == S_START);
    active_o = (state_q != S_IDLE);
  end

  // ---------------- queue and job datapath ----------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (abort_i) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push_fire) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)       rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_fire, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    cfg_desc_d  = cfg_desc_q;
    irq_en_d    = irq_en_q;
    completed_d = completed_q;
    err_d       = err_q;
    if (pop) begin
      cfg_desc_d = head.desc;
      irq_en_d   = head.irq_en;
    end
    if (done_ok) completed_d = completed_q + 1'b1;
    // Completions during or after an abort never interrupt.
    irq_d = done_i && (state_q == S_RUN) && !abort_i && irq_en_q;
    if (abort_i)       err_d = 1'b0;
    else if (done_bad) err_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (push_fire) mem_q[wr_ptr_q] <= '{desc: push_desc_i, irq_en: push_irq_en_i};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cfg_desc_q  <= '0;
      irq_en_q    <= 1'b0;
      completed_q <= '0;
      irq_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      cfg_desc_q  <= cfg_desc_d;
      irq_en_q    <= irq_en_d;
      completed_q <= completed_d;
      irq_q       <= irq_d;
      err_q       <= err_d;
    end
  end

  assign cfg_desc_o  = cfg_desc_q;
  assign pending_o   = count_q;
  assign completed_o = completed_q;
  assign irq_o       = irq_q;
  assign err_o       = err_q;

endmodule

// File: doc/ita_job_sequencer.md
# ita_job_sequencer

Queues ITA job descriptors from a requester, such as a cluster core or DMA-driven command list. Issues them one at a time to the ITA HWPE control path: registered configuration, then a one-cycle start. Waits for the engine's done pulse before issuing the next job. Also counts completed jobs, raises per-job interrupts and supports an abort that flushes pending work and drains the in-flight job.

## Interface
- DEPTH, 4, descriptor queue depth (power of two, ≥2)
- DESC_W, 128, opaque descriptor width forwarded unchanged to the engine configuration
- CNT_W, 16, completed-job counter width
- clk_i  input  1  clock; all state on rising edge
- rst_i  input  1  asynchronous, active-high reset
- push_valid_i  input  1  descriptor offered
- push_ready_o  output  1  descriptor accepted when valid&&ready
- push_desc_i  input  DESC_W  descriptor payload
- push_irq_en_i  input  1  raise irq_o when this job completes
- abort_i  input  1  single-cycle abort request
- cfg_desc_o  output  DESC_W  registered descriptor of current/last issued job
- start_o  output  1  one-cycle start pulse to engine controller
- done_i  input  1  one-cycle job-done pulse from engine controller
- active_o  output  1  a job is loaded, started or running (LOAD/START/RUN/ABORT)
- pending_o  output  $clog2(DEPTH)+1  queued descriptors not yet issued
- completed_o  output  CNT_W  jobs finished since reset, wraps
- irq_o  output  1  one-cycle completion interrupt
- err_o  output  1  sticky protocol error

## Operation
- States: IDLE, LOAD, START, RUN, ABORT.
- Queue: circular FIFO, DEPTH entries of {desc, irq_en}.
  - push_ready_o = !full && state!=ABORT && !abort_i (combinational).
  - No bypass: a push into an empty queue is not issued in the same cycle.
  - Simultaneous push and pop leaves the count unchanged. When full, no push is accepted even if a pop occurs that cycle.
- IDLE: if pending_o>0, pop the head into cfg_desc_o and the active irq_en register, then go to LOAD.
- LOAD: one setup cycle with cfg_desc_o stable; go to START.
- START: start_o=1 for exactly one cycle; go to RUN.
- RUN: on done_i:
  - completed_o += 1 (mod 2^CNT_W).
  - irq_o=1 in the next cycle if the active irq_en is set.
  - If pending_o>0, pop the next head at the same edge and go to LOAD. Otherwise go to IDLE.
- abort_i (any state), takes priority over every other event in that cycle:
  - Queue flushed (pending_o=0 at next edge).
  - err_o cleared.
  - State from IDLE/LOAD → IDLE; no start is issued for a loaded descriptor.
  - State from START/RUN → ABORT.
  - abort_i in START still drives start_o that cycle; the engine is then drained.
  - A done_i coincident with abort_i in RUN counts as the completion: increment completed_o, no irq_o, go to IDLE.
- ABORT: wait for done_i, then increment completed_o, no irq_o, go to IDLE. abort_i in ABORT has no further effect.
- done_i outside RUN/ABORT (including START) sets err_o and is otherwise ignored; counters and state are unchanged.
- cfg_desc_o holds its value until the next pop; it is not cleared on completion or abort.

## Timing
- Reset values while rst_i is high and after release:
  - state=IDLE; queue empty.
  - cfg_desc_o=0, start_o=0, active_o=0, pending_o=0, completed_o=0, irq_o=0, err_o=0.
  - push_ready_o=1.
- A reset asserted mid-job discards all state immediately; the engine is reset by the same rst_i.
- Issue latency from push accepted in cycle 0 with the sequencer idle:
  - pending_o=1 in cycle 1.
  - Pop at end of cycle 1: cfg_desc_o valid and LOAD in cycle 2.
  - start_o=1 in cycle 3.
  - RUN from cycle 4.
- Back-to-back: done_i in cycle k with pending>0 gives LOAD in k+1 (new cfg_desc_o), start_o in k+2, and irq_o (if enabled) in k+1.
- completed_o updates in the cycle after done_i.
- active_o and pending_o are registered-state derived, with no combinational path from inputs.

## Test plan
- Single job, irq_en=1, desc=0xA5…: push in cycle 0 → cfg_desc_o=desc in cycle 2, start_o only in cycle 3. done_i in cycle 10 → completed_o=1 and irq_o=1 in cycle 11, then IDLE.
- Fill 4 pushes with the engine stalled in RUN on job 0 → push_ready_o=0 after the 4th queued entry (pending_o=4). done_i → pop; pending_o=3 and ready=1 next cycle. Jobs issue in FIFO order, each start exactly 2 cycles after the previous done.
- Push and pop in the same cycle with pending_o=2 → pending_o stays 2. Push when full with a coincident pop → not accepted.
- abort_i in RUN with 3 pending → pending_o=0 next cycle, push_ready_o=0 until done_i. done_i → completed_o+1, no irq_o, IDLE, no further start_o.
- Spurious done_i in IDLE and in START → err_o=1 sticky, completed_o unchanged. A later abort_i clears err_o.
- completed_o wrap with CNT_W=4: 16 jobs → completed_o returns to 0. Also assert rst_i mid-RUN → all outputs at reset values in the same cycle.
